// File: rtl/usb_buffer_arbiter.sv
// Shares the single-port USB packet buffer between the core bus and the USB module.
// A two-state token decides the priority owner; the other side gets idle cycles plus a forced anti-starvation slot.
module usb_buffer_arbiter #(
  parameter int ADDR_WIDTH   = 8,
  parameter int STARVE_LIMIT = 15,
  parameter int CNT_WIDTH    = 4
) (
  input  logic                  clk48,
  input  logic                  reset,
  input  logic                  core_req,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [31:0]           core_wdata,
  input  logic [3:0]            core_wstrb,
  output logic                  core_grant,
  output logic                  core_rvalid,
  output logic [31:0]           core_rdata,
  input  logic                  usb_req,
  input  logic [ADDR_WIDTH-1:0] usb_addr,
  input  logic [31:0]           usb_wdata,
  input  logic                  usb_we,
  output logic                  usb_grant,
  output logic                  usb_rvalid,
  output logic [31:0]           usb_rdata,
  input  logic                  usb_packet_done,
  input  logic                  core_release,
  output logic                  core_owns,
  output logic                  protocol_error,
  output logic [ADDR_WIDTH-1:0] buf_addr,
  output logic [31:0]           buf_wdata,
  output logic [3:0]            buf_wstrb,
  input  logic [31:0]           buf_rdata
);

  typedef enum logic {USB_OWNS = 1'b0, CORE_OWNS = 1'b1} own_e;

  localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(STARVE_LIMIT);

  own_e                 r_state, w_state_nxt;
  logic                 r_err;
  logic                 w_err_evt;
  logic [CNT_WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic                 r_core_pend, r_usb_pend;
  logic [31:0]          r_core_rdata, r_usb_rdata;
  logic                 w_owner_req, w_non_req, w_force;
  logic                 w_owner_gnt, w_non_gnt;

  // Ownership token: the pulse valid for the current state moves it, the other one is a violation.
  always_ff @(posedge clk48 or posedge reset) begin
    if (reset) r_state <= USB_OWNS;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_err_evt   = 1'b0;
    case (r_state)
      USB_OWNS: begin
        if (usb_packet_done) w_state_nxt = CORE_OWNS;
        if (core_release)    w_err_evt   = 1'b1;
      end
      CORE_OWNS: begin
        if (core_release)    w_state_nxt = USB_OWNS;
        if (usb_packet_done) w_err_evt   = 1'b1;
      end
      default: w_state_nxt = USB_OWNS;
    endcase
  end

  always_ff @(posedge clk48 or posedge reset) begin
    if (reset)          r_err <= 1'b0;
    else if (w_err_evt) r_err <= 1'b1;
  end

  assign core_owns      = (r_state == CORE_OWNS);
  assign protocol_error = r_err;

  // Arbitration is owner-relative; map back to core/usb at the end.
  always_comb begin
    w_owner_req = core_owns ? core_req : usb_req;
    w_non_req   = core_owns ? usb_req  : core_req;
    w_force     = w_owner_req && w_non_req && (r_cnt == LIMIT);
    w_owner_gnt = w_owner_req && !w_force;
    w_non_gnt   = w_non_req && (!w_owner_req || w_force);
    core_grant  = core_owns ? w_owner_gnt : w_non_gnt;
    usb_grant   = core_owns ? w_non_gnt   : w_owner_gnt;
  end

  always_comb begin
    w_cnt_nxt = '0;
    if (w_non_req && !w_non_gnt)
      w_cnt_nxt = (r_cnt == LIMIT) ? r_cnt : r_cnt + 1'b1;
  end

  always_ff @(posedge clk48 or posedge reset) begin
    if (reset) r_cnt <= '0;
    else       r_cnt <= w_cnt_nxt;
  end

  always_comb begin
    buf_addr  = '0;
    buf_wdata = '0;
    buf_wstrb = '0;
    if (core_grant) begin
      buf_addr  = core_addr;
      buf_wdata = core_wdata;
      buf_wstrb = core_wstrb;
    end else if (usb_grant) begin
      buf_addr  = usb_addr;
      buf_wdata = usb_wdata;
      buf_wstrb = {4{usb_we}};
    end
  end

  // RAM data is registered, so the read issued in cycle N is on buf_rdata during N+1.
  always_ff @(posedge clk48 or posedge reset) begin
    if (reset) begin
      r_core_pend  <= 1'b0;
      r_usb_pend   <= 1'b0;
      r_core_rdata <= '0;
      r_usb_rdata  <= '0;
    end else begin
      r_core_pend <= core_grant && (core_wstrb == 4'b0000);
      r_usb_pend  <= usb_grant && !usb_we;
      if (r_core_pend) r_core_rdata <= buf_rdata;
      if (r_usb_pend)  r_usb_rdata  <= buf_rdata;
    end
  end

  assign core_rvalid = r_core_pend;
  assign usb_rvalid  = r_usb_pend;
  assign core_rdata  = r_core_pend ? buf_rdata : r_core_rdata;
  assign usb_rdata   = r_usb_pend  ? buf_rdata : r_usb_rdata;

endmodule

// File: tb/tb_usb_buffer_arbiter.sv
// Directed bench for usb_buffer_arbiter: behavioural buffer RAM, read-data scoreboard
// per requester, and inline checks on grants, RAM drive and ownership state.
module tb_usb_buffer_arbiter;

  logic        clk48 = 1'b0;
  logic        reset = 1'b1;
  logic        core_req = 1'b0, usb_req = 1'b0, usb_we = 1'b0;
  logic [7:0]  core_addr = '0, usb_addr = '0;
  logic [31:0] core_wdata = '0, usb_wdata = '0;
  logic [3:0]  core_wstrb = '0;
  logic        usb_packet_done = 1'b0, core_release = 1'b0;
  logic        core_grant, core_rvalid, usb_grant, usb_rvalid, core_owns, protocol_error;
  logic [31:0] core_rdata, usb_rdata, buf_wdata, buf_rdata;
  logic [7:0]  buf_addr;
  logic [3:0]  buf_wstrb;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] core_q[$];
  logic [31:0] usb_q[$];
  logic [31:0] mem [256];

  usb_buffer_arbiter dut (
    .clk48(clk48), .reset(reset),
    .core_req(core_req), .core_addr(core_addr), .core_wdata(core_wdata), .core_wstrb(core_wstrb),
    .core_grant(core_grant), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .usb_req(usb_req), .usb_addr(usb_addr), .usb_wdata(usb_wdata), .usb_we(usb_we),
    .usb_grant(usb_grant), .usb_rvalid(usb_rvalid), .usb_rdata(usb_rdata),
    .usb_packet_done(usb_packet_done), .core_release(core_release),
    .core_owns(core_owns), .protocol_error(protocol_error),
    .buf_addr(buf_addr), .buf_wdata(buf_wdata), .buf_wstrb(buf_wstrb), .buf_rdata(buf_rdata)
  );

  always #10 clk48 = ~clk48;

  initial for (int i = 0; i < 256; i++) mem[i] = '0;

  always @(posedge clk48) begin
    for (int b = 0; b < 4; b++)
      if (buf_wstrb[b]) mem[buf_addr][8*b +: 8] <= buf_wdata[8*b +: 8];
    buf_rdata <= mem[buf_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk48);
    #1;
  endtask

  task automatic smp();
    @(negedge clk48);
  endtask

  // Monitor: every rvalid must match the oldest outstanding expectation of its requester.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk48);
      if (!reset) begin
        if (core_rvalid) begin
          if (core_q.size() == 0) chk("core_rvalid_unexpected", 32'd1, 32'd0);
          else begin e = core_q.pop_front(); chk("core_rdata", core_rdata, e); end
        end
        if (usb_rvalid) begin
          if (usb_q.size() == 0) chk("usb_rvalid_unexpected", 32'd1, 32'd0);
          else begin e = usb_q.pop_front(); chk("usb_rdata", usb_rdata, e); end
        end
      end
    end
  end

  initial begin
    // Reset and idle
    repeat (3) @(posedge clk48);
    #1 reset = 1'b0;
    smp();
    chk("rst_core_owns", 32'(core_owns), 0);
    chk("rst_grants", {30'd0, core_grant, usb_grant}, 0);
    chk("rst_rvalid", {30'd0, core_rvalid, usb_rvalid}, 0);
    chk("rst_buf_wstrb", 32'(buf_wstrb), 0);
    chk("rst_perr", 32'(protocol_error), 0);
    chk("rst_core_rdata", core_rdata, 0);

    // USB writes a packet word, hands over, core reads it back
    nxt(); usb_req = 1; usb_addr = 8'd5; usb_wdata = 32'hDEADBEEF; usb_we = 1;
    smp();
    chk("usbw_grant", 32'(usb_grant), 1);
    chk("usbw_core_grant", 32'(core_grant), 0);
    chk("usbw_wstrb", 32'(buf_wstrb), 32'hF);
    chk("usbw_addr", 32'(buf_addr), 5);
    chk("usbw_wdata", buf_wdata, 32'hDEADBEEF);
    nxt(); usb_req = 0; usb_we = 0; usb_packet_done = 1;
    smp(); chk("pd_same_cycle_owns", 32'(core_owns), 0);
    nxt(); usb_packet_done = 0; core_req = 1; core_addr = 8'd5; core_wstrb = 4'b0000;
    smp();
    chk("pd_core_owns", 32'(core_owns), 1);
    chk("core_rd_grant", 32'(core_grant), 1);
    core_q.push_back(32'hDEADBEEF);
    nxt(); core_req = 0;
    smp(); chk("perr_clean", 32'(protocol_error), 0);

    // Starvation: core owner writes byte lane 2 continuously, USB reads continuously
    nxt(); core_req = 1; core_addr = 8'd10; core_wdata = 32'h00AA0000; core_wstrb = 4'b0100;
    usb_req = 1; usb_addr = 8'd5; usb_we = 0;
    for (int i = 0; i < 32; i++) begin
      logic ug;
      smp();
      ug = (i == 15) || (i == 31);
      chk("starve_core_grant", 32'(core_grant), 32'(!ug));
      chk("starve_usb_grant", 32'(usb_grant), 32'(ug));
      chk("starve_wstrb", 32'(buf_wstrb), ug ? 32'h0 : 32'h4);
      if (ug) usb_q.push_back(32'hDEADBEEF);
      if (i < 31) nxt();
    end
    nxt(); usb_req = 0; core_wstrb = 4'b0000;
    smp(); chk("lane_rd_grant", 32'(core_grant), 1);
    core_q.push_back(32'h00AA0000);
    nxt(); core_req = 0;

    // Handovers and protocol violations
    core_release = 1;
    smp(); chk("rel_same_cycle_owns", 32'(core_owns), 1);
    nxt(); core_release = 0;
    smp();
    chk("rel_owns", 32'(core_owns), 0);
    chk("rel_perr", 32'(protocol_error), 0);
    nxt(); core_release = 1;
    nxt(); core_release = 0;
    smp();
    chk("bad_rel_perr", 32'(protocol_error), 1);
    chk("bad_rel_owns", 32'(core_owns), 0);
    nxt(); nxt();
    smp(); chk("perr_sticky", 32'(protocol_error), 1);
    nxt(); usb_packet_done = 1; core_release = 1;
    nxt(); usb_packet_done = 0; core_release = 0;
    smp();
    chk("both_pulse_owns", 32'(core_owns), 1);
    chk("both_pulse_perr", 32'(protocol_error), 1);

    // Build up the starvation counter, then reset right after a granted read
    nxt(); core_req = 1; core_addr = 8'd5; core_wstrb = 4'b0000;
    usb_req = 1; usb_addr = 8'd5; usb_we = 0;
    for (int i = 0; i < 6; i++) begin
      smp();
      chk("pre_rst_core_grant", 32'(core_grant), 1);
      chk("pre_rst_usb_grant", 32'(usb_grant), 0);
      if (i < 5) begin core_q.push_back(32'hDEADBEEF); nxt(); end
    end
    nxt(); reset = 1; core_req = 0; usb_req = 0;
    smp();
    chk("rst_mid_rvalid", 32'(core_rvalid), 0);
    chk("rst_mid_owns", 32'(core_owns), 0);
    nxt(); nxt(); reset = 0;
    smp();
    chk("rst2_rvalid", {30'd0, core_rvalid, usb_rvalid}, 0);
    chk("rst2_perr", 32'(protocol_error), 0);
    chk("rst2_core_rdata", core_rdata, 0);
    chk("rst2_usb_rdata", usb_rdata, 0);

    // USB now owns; counter must start from 0, so core is forced in on the 16th cycle
    nxt(); core_req = 1; core_addr = 8'd20; core_wdata = 32'h00000011; core_wstrb = 4'b0001;
    usb_req = 1; usb_addr = 8'd5; usb_we = 0;
    for (int i = 0; i < 16; i++) begin
      logic cg;
      smp();
      cg = (i == 15);
      chk("post_rst_core_grant", 32'(core_grant), 32'(cg));
      chk("post_rst_usb_grant", 32'(usb_grant), 32'(!cg));
      if (!cg) usb_q.push_back(32'hDEADBEEF);
      if (i < 15) nxt();
    end
    chk("forced_wstrb", 32'(buf_wstrb), 32'h1);

    // Alternating reads with no owner traffic
    nxt(); usb_req = 0; core_req = 1; core_addr = 8'd1; core_wdata = 32'h11111111; core_wstrb = 4'hF;
    smp(); chk("alt_cw_grant", 32'(core_grant), 1);
    nxt(); core_req = 0; usb_req = 1; usb_addr = 8'd2; usb_wdata = 32'h22222222; usb_we = 1;
    smp(); chk("alt_uw_grant", 32'(usb_grant), 1);
    nxt(); usb_we = 0; core_wstrb = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      core_req = (i % 2 == 0);
      usb_req  = (i % 2 == 1);
      smp();
      chk("alt_core_grant", 32'(core_grant), 32'(i % 2 == 0));
      chk("alt_usb_grant", 32'(usb_grant), 32'(i % 2 == 1));
      if (i % 2 == 0) core_q.push_back(32'h11111111);
      else            usb_q.push_back(32'h22222222);
      nxt();
    end
    core_req = 0; usb_req = 0;
    smp(); nxt(); smp(); nxt(); smp();
    chk("core_q_drained", core_q.size(), 0);
    chk("usb_q_drained", usb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
